// File: rtl/mov_sprite_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mov_sprite_fetch : per-line object scan + 3-stage pattern fetch pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
module mov_sprite_fetch #(
  parameter int NUM_OBJ = 8,
  parameter int COORD_W = 10,
  localparam int OW = $clog2(NUM_OBJ)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               obj_wen,
  input  logic [OW-1:0]      obj_addr,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [5:0]         obj_sel,
  input  logic               obj_en,
  input  logic               line_start,
  input  logic [COORD_W-1:0] next_line,
  input  logic [COORD_W-1:0] pix_x,
  input  logic               pix_valid_in,
  output logic [5:0]         spr_select,
  output logic [3:0]         spr_x,
  output logic [3:0]         spr_y,
  input  logic [1:0]         spr_data,
  output logic [1:0]         pix_out,
  output logic               pix_hit,
  output logic               pix_valid_out
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  logic [COORD_W-1:0] r_tab_x   [NUM_OBJ];
  logic [COORD_W-1:0] r_tab_y   [NUM_OBJ];
  logic [5:0]         r_tab_sel [NUM_OBJ];
  logic [NUM_OBJ-1:0] r_tab_en;

  state_t             r_state;
  logic [OW-1:0]      r_idx;
  logic [COORD_W-1:0] r_line;
  logic [NUM_OBJ-1:0] r_sh_act;
  logic [NUM_OBJ-1:0] r_lv_act;
  logic [3:0]         r_sh_row [NUM_OBJ];
  logic [3:0]         r_lv_row [NUM_OBJ];

  logic r_hit_b, r_val_b, r_hit_c, r_val_c;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_tab_x[i]   <= '0;
        r_tab_y[i]   <= '0;
        r_tab_sel[i] <= '0;
      end
      r_tab_en <= '0;
    end else if (obj_wen) begin
      r_tab_x[obj_addr]   <= obj_x;
      r_tab_y[obj_addr]   <= obj_y;
      r_tab_sel[obj_addr] <= obj_sel;
      r_tab_en[obj_addr]  <= obj_en;
    end
  end

  // Once line >= y holds, line-y < 16 is the same as line < y+16 without wrap.
  logic [COORD_W-1:0] w_dy;
  logic               w_scan_hit;
  assign w_dy       = r_line - r_tab_y[r_idx];
  assign w_scan_hit = r_tab_en[r_idx] && (r_line >= r_tab_y[r_idx]) && (w_dy < COORD_W'(16));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_line   <= '0;
      r_sh_act <= '0;
      r_lv_act <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_sh_row[i] <= '0;
        r_lv_row[i] <= '0;
      end
    end else if (line_start) begin
      r_lv_act <= r_sh_act;
      for (int i = 0; i < NUM_OBJ; i++) r_lv_row[i] <= r_sh_row[i];
      r_line   <= next_line;
      r_sh_act <= '0;
      r_idx    <= '0;
      r_state  <= ST_SCAN;
    end else if (r_state == ST_SCAN) begin
      r_sh_act[r_idx] <= w_scan_hit;
      r_sh_row[r_idx] <= w_dy[3:0];
      r_idx           <= r_idx + 1'b1;
      if (r_idx == OW'(NUM_OBJ - 1)) r_state <= ST_IDLE;
    end
  end

  logic [COORD_W-1:0] w_dx [NUM_OBJ];
  logic [NUM_OBJ-1:0] w_cover;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_cover
    assign w_dx[g]    = pix_x - r_tab_x[g];
    assign w_cover[g] = r_lv_act[g] && (pix_x >= r_tab_x[g]) && (w_dx[g] < COORD_W'(16));
  end

  logic          w_any;
  logic [OW-1:0] w_win;

  // Descending walk so the lowest covering index is the one left standing.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (w_cover[i]) begin
        w_any = 1'b1;
        w_win = OW'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      spr_select    <= '0;
      spr_x         <= '0;
      spr_y         <= '0;
      r_hit_b       <= 1'b0;
      r_val_b       <= 1'b0;
      r_hit_c       <= 1'b0;
      r_val_c       <= 1'b0;
      pix_out       <= '0;
      pix_hit       <= 1'b0;
      pix_valid_out <= 1'b0;
    end else begin
      spr_select    <= w_any ? r_tab_sel[w_win]  : 6'd0;
      spr_x         <= w_any ? w_dx[w_win][3:0]  : 4'd0;
      spr_y         <= w_any ? r_lv_row[w_win]   : 4'd0;
      r_hit_b       <= w_any && pix_valid_in;
      r_val_b       <= pix_valid_in;
      r_hit_c       <= r_hit_b;
      r_val_c       <= r_val_b;
      pix_out       <= r_hit_c ? spr_data : 2'b00;
      pix_hit       <= r_hit_c && (spr_data != 2'b00);
      pix_valid_out <= r_val_c;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mov_sprite_fetch.sv
`default_nettype none
// Bench for mov_sprite_fetch: reference model + directed vector table + random traffic.
module tb_mov_sprite_fetch;
  localparam int NUM_OBJ = 8;
  localparam int COORD_W = 10;
  localparam int OW      = 3;

  logic               clock, resetn, obj_wen, obj_en, line_start, pix_valid_in;
  logic [OW-1:0]      obj_addr;
  logic [COORD_W-1:0] obj_x, obj_y, next_line, pix_x;
  logic [5:0]         obj_sel, spr_select;
  logic [3:0]         spr_x, spr_y;
  logic [1:0]         spr_data, pix_out;
  logic               pix_hit, pix_valid_out;

  mov_sprite_fetch #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W)) dut (
    .clock(clock), .resetn(resetn), .obj_wen(obj_wen), .obj_addr(obj_addr),
    .obj_x(obj_x), .obj_y(obj_y), .obj_sel(obj_sel), .obj_en(obj_en),
    .line_start(line_start), .next_line(next_line), .pix_x(pix_x),
    .pix_valid_in(pix_valid_in), .spr_select(spr_select), .spr_x(spr_x),
    .spr_y(spr_y), .spr_data(spr_data), .pix_out(pix_out), .pix_hit(pix_hit),
    .pix_valid_out(pix_valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  int mem_mode = 2;  // 0: hashed pattern, 1: all transparent, 2: all code 2

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] memf(input logic [5:0] s, input logic [3:0] xx, input logic [3:0] yy);
    logic [5:0] t;
    if (mem_mode == 1) return 2'b00;
    if (mem_mode == 2) return 2'b10;
    t = s ^ {2'b00, xx} ^ {1'b0, yy, 1'b0};
    return t[1:0] ^ t[3:2];
  endfunction

  // Pattern memory: one-cycle synchronous read.
  always @(posedge clock) spr_data <= memf(spr_select, spr_x, spr_y);

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0] sel; logic [3:0] xo; logic [3:0] row;
    logic hit; logic valid; logic [1:0] out;
  } rec_t;

  logic [COORD_W-1:0] m_x [NUM_OBJ];
  logic [COORD_W-1:0] m_y [NUM_OBJ];
  logic [5:0]         m_sel [NUM_OBJ];
  bit                 m_en [NUM_OBJ];
  bit                 m_sh [NUM_OBJ];
  bit                 m_lv [NUM_OBJ];
  int                 m_shr [NUM_OBJ];
  int                 m_lvr [NUM_OBJ];
  int                 m_line, m_pos;
  rec_t               p1, p2, p3;

  always @(posedge clock) begin
    rec_t r;
    int   px, win;
    bit   found;
    if (!resetn) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        m_x[i] = '0; m_y[i] = '0; m_sel[i] = '0; m_en[i] = 0;
        m_sh[i] = 0; m_lv[i] = 0; m_shr[i] = 0; m_lvr[i] = 0;
      end
      m_line = 0; m_pos = NUM_OBJ;
      p1 = '0; p2 = '0; p3 = '0;
    end else begin
      r = '0; px = int'(pix_x); found = 0; win = 0;
      for (int i = 0; i < NUM_OBJ; i++)
        if (!found && m_lv[i] && px >= int'(m_x[i]) && px - int'(m_x[i]) < 16) begin
          found = 1; win = i;
        end
      if (found) begin
        r.sel = m_sel[win];
        r.xo  = 4'(px - int'(m_x[win]));
        r.row = 4'(m_lvr[win]);
        r.hit = pix_valid_in;
      end
      r.valid = pix_valid_in;
      r.out   = r.hit ? memf(r.sel, r.xo, r.row) : 2'b00;
      p3 = p2; p2 = p1; p1 = r;
      if (line_start) begin
        m_lv = m_sh; m_lvr = m_shr;
        for (int i = 0; i < NUM_OBJ; i++) m_sh[i] = 0;
        m_line = int'(next_line); m_pos = 0;
      end else if (m_pos < NUM_OBJ) begin
        m_sh[m_pos]  = m_en[m_pos] && m_line >= int'(m_y[m_pos]) && m_line < int'(m_y[m_pos]) + 16;
        m_shr[m_pos] = m_line - int'(m_y[m_pos]);
        m_pos++;
      end
      if (obj_wen) begin
        m_x[obj_addr] = obj_x; m_y[obj_addr] = obj_y;
        m_sel[obj_addr] = obj_sel; m_en[obj_addr] = obj_en;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_select", spr_select, p1.sel);
      chk("m_sprx", spr_x, p1.xo);
      chk("m_spry", spr_y, p1.row);
      chk("m_out", pix_out, p3.out);
      chk("m_hit", pix_hit, (p3.out != 2'b00));
      chk("m_valid", pix_valid_out, p3.valid);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input int a, input int x, input int y, input int s, input bit en);
    obj_wen = 1; obj_addr = OW'(a); obj_x = COORD_W'(x); obj_y = COORD_W'(y);
    obj_sel = 6'(s); obj_en = en;
    tick(1);
    obj_wen = 0;
  endtask

  task automatic ls(input int l);
    line_start = 1; next_line = COORD_W'(l);
    tick(1);
    line_start = 0;
  endtask

  // Scan line l, then promote it to live with a second line_start.
  task automatic setline(input int l);
    ls(l); tick(NUM_OBJ + 2);
    ls(l + 1); tick(NUM_OBJ + 2);
  endtask

  task automatic probe(input string nm, input int px, input bit hit, input int sel,
                       input int sx, input int sy, input logic [1:0] exp_out);
    pix_x = COORD_W'(px); pix_valid_in = 1;
    tick(1);
    chk({nm, "_sel"}, spr_select, sel);
    chk({nm, "_sx"}, spr_x, sx);
    chk({nm, "_sy"}, spr_y, sy);
    tick(2);
    chk({nm, "_hit"}, pix_hit, hit && exp_out != 2'b00);
    chk({nm, "_out"}, pix_out, hit ? exp_out : 2'b00);
    pix_valid_in = 0;
    tick(4);
  endtask

  typedef struct { int line; int px; bit hit; int row; int sel; int sx; } vec_t;
  vec_t vt [16];

  initial begin
    int prev;
    vt[0]  = '{55, 95, 0, 0, 0, 0};
    vt[1]  = '{55, 99, 0, 0, 0, 0};
    vt[2]  = '{55, 100, 1, 5, 1, 0};
    vt[3]  = '{55, 101, 1, 5, 1, 1};
    vt[4]  = '{55, 108, 1, 5, 1, 8};
    vt[5]  = '{55, 115, 1, 5, 1, 15};
    vt[6]  = '{55, 116, 0, 0, 0, 0};
    vt[7]  = '{55, 200, 1, 5, 3, 10};
    vt[8]  = '{55, 208, 1, 3, 7, 13};
    vt[9]  = '{59, 305, 0, 0, 0, 0};
    vt[10] = '{60, 305, 1, 0, 9, 5};
    vt[11] = '{75, 305, 1, 15, 9, 5};
    vt[12] = '{76, 305, 0, 0, 0, 0};
    vt[13] = '{1023, 400, 1, 3, 12, 0};
    vt[14] = '{2, 400, 0, 0, 0, 0};
    vt[15] = '{5, 1023, 1, 5, 20, 8};

    resetn = 0; obj_wen = 0; obj_addr = '0; obj_x = '0; obj_y = '0; obj_sel = '0;
    obj_en = 0; line_start = 0; next_line = '0; pix_x = '0; pix_valid_in = 0;
    tick(2);
    chk_en = 1;
    chk("rst_sel", spr_select, 0); chk("rst_sx", spr_x, 0); chk("rst_sy", spr_y, 0);
    chk("rst_out", pix_out, 0); chk("rst_hit", pix_hit, 0); chk("rst_valid", pix_valid_out, 0);
    resetn = 1;

    // Empty table: pixels and line starts never produce a hit.
    for (int i = 0; i < 30; i++) begin
      pix_x = COORD_W'($urandom_range(0, 1023)); pix_valid_in = ($urandom % 4) != 0;
      line_start = (i % 10) == 0; next_line = COORD_W'(i);
      tick(1);
      chk("empty_hit", pix_hit, 0);
      chk("empty_out", pix_out, 0);
    end
    line_start = 0; pix_valid_in = 0; tick(4);

    wr(0, 100, 50, 1, 1);
    wr(2, 190, 50, 3, 1);
    wr(5, 195, 52, 7, 1);
    wr(3, 300, 60, 9, 1);
    wr(4, 400, 1020, 12, 1);
    wr(6, 1015, 0, 20, 1);

    prev = -1;
    for (int i = 0; i < 16; i++) begin
      if (vt[i].line != prev) setline(vt[i].line);
      prev = vt[i].line;
      probe($sformatf("vec%0d", i), vt[i].px, vt[i].hit, vt[i].sel, vt[i].sx, vt[i].row, 2'b10);
    end
    // Clipped at the right screen edge: no wrap to column 2.
    probe("clip", 2, 0, 0, 0, 0, 2'b10);

    // Transparent winner pixel must not fall through to object 5.
    setline(55);
    mem_mode = 1;
    probe("prio_t", 200, 1, 3, 10, 5, 2'b00);
    mem_mode = 2;

    // Disable object 1 after the scan has passed it.
    wr(1, 500, 70, 11, 1);
    ls(72); tick(10);
    ls(73); tick(3);
    wr(1, 500, 70, 11, 0);
    tick(10);
    ls(74); tick(10);
    probe("late_on", 505, 1, 11, 5, 3, 2'b10);
    ls(75); tick(10);
    probe("late_off", 505, 0, 0, 0, 0, 2'b10);

    // Reset while hits are streaming.
    mem_mode = 0;
    setline(55);
    for (int i = 0; i < 6; i++) begin
      pix_x = COORD_W'(100 + i); pix_valid_in = 1; tick(1);
    end
    resetn = 0; tick(1);
    chk("mrst_sel", spr_select, 0); chk("mrst_sx", spr_x, 0); chk("mrst_sy", spr_y, 0);
    chk("mrst_out", pix_out, 0); chk("mrst_hit", pix_hit, 0); chk("mrst_valid", pix_valid_out, 0);
    resetn = 1;
    wr(0, 100, 50, 1, 1);
    for (int i = 0; i < 12; i++) begin
      pix_x = COORD_W'(100 + i); pix_valid_in = 1; tick(1);
      chk("post_rst_hit", pix_hit, 0);
    end
    pix_valid_in = 0; tick(4);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      obj_wen = ($urandom % 8) == 0;
      obj_addr = OW'($urandom); obj_x = COORD_W'($urandom_range(0, 255));
      obj_y = COORD_W'($urandom_range(0, 40)); obj_sel = 6'($urandom);
      obj_en = ($urandom % 4) != 0;
      line_start = ($urandom % 12) == 0; next_line = COORD_W'($urandom_range(0, 50));
      pix_x = COORD_W'($urandom_range(0, 255)); pix_valid_in = ($urandom % 8) != 0;
      tick(1);
    end
    obj_wen = 0; line_start = 0; pix_valid_in = 0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mov_sprite_fetch.md
Name: mov_sprite_fetch

Overview:
- Upstream address generator and downstream pixel consumer for the moving-sprite pattern memory (16x16 patterns, 2-bit pixels, 64 pattern selects, 1-cycle synchronous read).
- Holds a small table of on-screen moving objects (position, pattern select, enable).
- Scans the table once per video line to find the objects on the next line.
- Per active pixel, drives select/x/y into the pattern memory, then realigns the returned 2-bit code with the pixel stream for the colour mixer.

Parameters:
- NUM_OBJ, 8, number of object table entries (power of 2, 2..16); index width OW = log2(NUM_OBJ).
- COORD_W, 10, width of screen coordinates.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- resetn  in  1  synchronous, active-low reset.
- obj_wen  in  1  object table write strobe.
- obj_addr  in  OW  entry written.
- obj_x  in  COORD_W  sprite left edge.
- obj_y  in  COORD_W  sprite top edge.
- obj_sel  in  6  pattern select.
- obj_en  in  1  entry enable.
- line_start  in  1  one-cycle pulse at start of horizontal blank.
- next_line  in  COORD_W  line number to be displayed after this blank; sampled with line_start.
- pix_x  in  COORD_W  current pixel column.
- pix_valid_in  in  1  pixel is in active video.
- spr_select  out  6  pattern select to sprite memory.
- spr_x  out  4  column within pattern.
- spr_y  out  4  row within pattern.
- spr_data  in  2  pattern pixel from sprite memory, 1 cycle after address.
- pix_out  out  2  sprite pixel code, 0 = transparent.
- pix_hit  out  1  opaque sprite pixel present.
- pix_valid_out  out  1  delayed pix_valid_in.

Behaviour:
- Reset (resetn=0 at edge), state after the edge:
  - All table entries: en=0, x=y=sel=0.
  - Shadow and live masks and row arrays 0; FSM in IDLE.
  - All outputs 0; pipeline valid bits 0.
- Table write: on obj_wen=1, entry obj_addr is loaded at the edge. A write during SCAN is seen only if the scan index has not yet passed that entry; otherwise it takes effect on the next line.
- Line scan FSM, states IDLE and SCAN:
  - In IDLE, line_start=1 does three things at the edge:
    - Copies the shadow mask/rows to live.
    - Latches next_line.
    - Clears the shadow, sets idx=0, enters SCAN.
  - SCAN, one entry per cycle: shadow_active[idx] = en && L >= y && L < y+16, compared at COORD_W+1 bits with no wrap. shadow_row[idx] = (L-y)[3:0].
  - SCAN lasts exactly NUM_OBJ cycles, then returns to IDLE.
  - line_start during SCAN: the partial shadow is copied to live, then the scan restarts for the new line. A bench sees a truncated mask for that line; this is the decided behaviour.
- Pixel pipeline:
  - Stage A (combinational on inputs): cover[i] = live_active[i] && pix_x >= x[i] && pix_x - x[i] < 16, at COORD_W+1 bits. Winner = lowest index with cover set; hitA = any cover && pix_valid_in.
  - Edge k+1: spr_select = sel[winner], spr_x = (pix_x - x[winner])[3:0], spr_y = live_row[winner]. Also register hitB and validB. With no winner, the address outputs hold 0.
  - Edge k+2: the memory presents spr_data. hitC and validC are registered to align.
  - Edge k+3: pix_out = hitC ? spr_data : 0; pix_hit = hitC && spr_data != 0; pix_valid_out = validC.
  - Total latency from pix_x/pix_valid_in to pix_out: 3 cycles, fully pipelined at one pixel per cycle.
- Priority: lower index is drawn. A transparent (00) winner pixel does not fall through to higher indices.
- Edges:
  - A sprite at x > screen width - 16 is clipped naturally.
  - A sprite at y near the max coordinate never matches beyond 2^COORD_W - 1.
  - pix_valid_in=0 forces hit=0 through the pipe.
- Mid-operation reset: the pipeline flushes and the table clears on the same edge. Outputs read 0 from the first cycle after reset.

Test Plan:
- Reset, then drive pixels with no writes -> pix_hit=0 and pix_out=0 everywhere; pix_valid_out equals pix_valid_in delayed 3 cycles.
- Object 0 at (100,50), sel=1, en=1; line_start with next_line=55, then a second line_start; sweep pix_x 95..120 -> spr_y=5, spr_x 0..15 for pix_x 100..115, spr_select=1; hit only for those pixels, pix_out = spr_data one edge after.
- Objects 2 (sel 3) and 5 (sel 7), both covering pix_x=200 on the same line -> spr_select=3; with memory returning 00, pix_hit=0, with no fall-through to sel 7.
- Object at y=60, next_line=59 and next_line=76 -> no hit; next_line=60 gives row 0 and next_line=75 gives row 15, hit.
- Write object 1 en=0 during SCAN after idx passed 1 -> object 1 still drawn this line, gone the line after.
- Assert resetn=0 mid-line while hits stream -> all outputs 0 next cycle; after release, a line_start is required before any hit.
